// File: rtl/sha3_bus_pkg.sv
// Shared bus constants and the burst FSM state type for the OCM read path.
// Pure declarations, no logic, no latency.
// No handshakes live here.
package sha3_bus_pkg;

  localparam int          BEAT_BYTES     = 16;
  localparam logic [2:0]  AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  // Also decoded by the downstream loader debug port, so keep the order fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    FINISH = 2'd3
  } burst_state_t;

endpackage

// File: rtl/sha3_burst_reader_burst_len_calc.sv
// Beats for the next burst: min(remaining beats, MAX_BURST, beats left in the 4 KB page).
// Purely combinational, zero latency.
// No flow control; the caller holds the inputs stable while AR is pending.
module burst_len_calc #(
  parameter int BL_W      = 16,
  parameter int MAX_BURST = 16
) (
  input  logic [BL_W-1:0] beats_left,
  input  logic [7:0]      addr_idx,
  output logic [BL_W-1:0] beats,
  output logic [7:0]      arlen
);

  logic [8:0]      to_4k;
  logic [BL_W-1:0] cap_max;
  logic [BL_W-1:0] cap_page;

  // Clip the remaining length first by the burst cap, then by the page edge.
  // arlen wraps correctly for a 256-beat burst because only 8 bits are kept.
  always_comb begin
    to_4k    = 9'd256 - {1'b0, addr_idx};
    cap_max  = (beats_left < BL_W'(MAX_BURST)) ? beats_left : BL_W'(MAX_BURST);
    cap_page = (cap_max < BL_W'(to_4k)) ? cap_max : BL_W'(to_4k);
    beats    = cap_page;
    arlen    = cap_page[7:0] - 8'd1;
  end

endmodule

// File: rtl/sha3_burst_reader.sv
// AXI4 INCR burst read master streaming a message from OCM into the hash loader FIFO.
// Latency: each R beat appears on ocm_data_out one cycle after its handshake.
// New bursts wait for dfsm_read_ready; rready never drops mid-burst since room was reserved.
module sha3_burst_reader
  import sha3_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length_bytes,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [DATA_W-1:0] ocm_data_out,
  output logic              bus_data_valid,
  input  logic              dfsm_read_ready,
  output logic [31:0]       read_addr_offset
);

  localparam int BL_W = LEN_W - 4;

  burst_state_t      state;
  logic [ADDR_W-1:0] addr;
  logic [BL_W-1:0]   beats_left;
  logic [31:0]       offset;
  logic [BL_W-1:0]   calc_beats;
  logic [7:0]        calc_arlen;

  // addr and beats_left only move on the AR handshake, so the calc output is
  // still valid when the handshake arrives and needs no separate register.
  burst_len_calc #(
    .BL_W      (BL_W),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .beats_left (beats_left),
    .addr_idx   (addr[11:4]),
    .beats      (calc_beats),
    .arlen      (calc_arlen)
  );

  assign m_arsize  = AXI_SIZE_16B;
  assign m_arburst = AXI_BURST_INCR;

  // Job FSM: issue one burst at a time, forward every beat, pulse done at the end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      addr             <= '0;
      beats_left       <= '0;
      offset           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      m_araddr         <= '0;
      m_arlen          <= '0;
      m_arvalid        <= 1'b0;
      m_rready         <= 1'b0;
      ocm_data_out     <= '0;
      bus_data_valid   <= 1'b0;
      read_addr_offset <= '0;
    end else begin
      done           <= 1'b0;
      bus_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (length_bytes == '0) begin
              done <= 1'b1;
            end else begin
              addr       <= base_addr;
              beats_left <= length_bytes[LEN_W-1:4];
              offset     <= '0;
              busy       <= 1'b1;
              state      <= ADDR;
            end
          end
        end
        ADDR: begin
          if (!m_arvalid) begin
            // Only request when the FIFO can absorb a whole burst.
            if (dfsm_read_ready) begin
              m_arvalid <= 1'b1;
              m_araddr  <= addr;
              m_arlen   <= calc_arlen;
            end
          end else if (m_arready) begin
            m_arvalid  <= 1'b0;
            addr       <= addr + ADDR_W'({calc_beats, 4'b0000});
            beats_left <= beats_left - calc_beats;
            m_rready   <= 1'b1;
            state      <= DATA;
          end
        end
        DATA: begin
          if (m_rvalid && m_rready) begin
            bus_data_valid   <= 1'b1;
            ocm_data_out     <= m_rdata;
            read_addr_offset <= offset;
            offset           <= offset + 32'(BEAT_BYTES);
            if (m_rresp != AXI_RESP_OKAY) begin
              err <= 1'b1;
            end
            if (m_rlast) begin
              m_rready <= 1'b0;
              state    <= (beats_left != '0) ? ADDR : FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_burst_reader.sv
// Randomised AXI slave plus scoreboard around sha3_burst_reader.
// Bursts are predicted from the page/length rules, beats from the slave's own data log.
// Inputs are driven and outputs sampled on the falling edge.
module tb_sha3_burst_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic [19:0]  length_bytes;
  logic         busy, done, err;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arvalid;
  logic         m_arready;
  logic [127:0] m_rdata;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic         m_rvalid;
  logic         m_rready;
  logic [127:0] ocm_data_out;
  logic         bus_data_valid;
  logic         dfsm_read_ready;
  logic [31:0]  read_addr_offset;

  sha3_burst_reader dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .length_bytes     (length_bytes),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .m_araddr         (m_araddr),
    .m_arlen          (m_arlen),
    .m_arsize         (m_arsize),
    .m_arburst        (m_arburst),
    .m_arvalid        (m_arvalid),
    .m_arready        (m_arready),
    .m_rdata          (m_rdata),
    .m_rresp          (m_rresp),
    .m_rlast          (m_rlast),
    .m_rvalid         (m_rvalid),
    .m_rready         (m_rready),
    .ocm_data_out     (ocm_data_out),
    .bus_data_valid   (bus_data_valid),
    .dfsm_read_ready  (dfsm_read_ready),
    .read_addr_offset (read_addr_offset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave / scoreboard state shared between the stimulus and slave processes.
  logic [31:0]  exp_ar_addr[$];
  logic [7:0]   exp_ar_len[$];
  logic [127:0] exp_data[$];
  int  job_beats      = 0;   // beats seen on bus_data_valid this job
  int  job_ars        = 0;   // AR handshakes this job
  int  job_beat_sent  = 0;   // R beats accepted by the DUT this job
  int  last_pulse_cyc = -10;
  int  s_left         = 0;
  bit  hold           = 0;
  bit  abort          = 0;
  bit  gaps           = 0;
  bit  ar_rand        = 0;
  int  err_beat       = -1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Burst list from the job rules: min(remaining, 16, beats to 4 KB page end).
  task automatic build_model(input logic [31:0] base, input int len);
    logic [31:0] a;
    int left, b, room;
    a    = base;
    left = len / 16;
    while (left > 0) begin
      b    = (left > 16) ? 16 : left;
      room = 256 - int'((a >> 4) & 32'hFF);
      if (b > room) b = room;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(8'(b - 1));
      a    = a + 32'(16 * b);
      left = left - b;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_bdv", bus_data_valid, 0);
    chk("rst_data", ocm_data_out, 0);
    chk("rst_offset", read_addr_offset, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arlen", m_arlen, 0);
  endtask

  // Slave and output monitor, both on the falling edge.
  initial begin
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset && bus_data_valid) begin
        if (exp_data.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("beat_data", ocm_data_out, exp_data.pop_front());
        chk("beat_offset", read_addr_offset, 32'(job_beats * 16));
        job_beats++;
        last_pulse_cyc = cyc;
      end
      if (!reset || abort) begin
        m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rresp = 0;
        s_left = 0; hold = 0;
      end else begin
        if (!hold) begin
          if (s_left > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            m_rvalid = 1;
            m_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m_rresp  = (job_beat_sent == err_beat) ? 2'b10 : 2'b00;
            m_rlast  = (s_left == 1);
          end else begin
            m_rvalid = 0; m_rlast = 0; m_rresp = 0;
          end
        end
        if (m_rvalid && m_rready) begin
          exp_data.push_back(m_rdata);
          s_left--;
          job_beat_sent++;
          hold = 0;
        end else begin
          hold = m_rvalid;
        end
        m_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_arvalid && m_arready) begin
          chk("ar_single_outstanding", (s_left == 0), 1);
          if (exp_ar_addr.size() == 0) begin
            chk("ar_unexpected", 1, 0);
          end else begin
            chk("ar_addr", m_araddr, exp_ar_addr.pop_front());
            chk("ar_len", m_arlen, exp_ar_len.pop_front());
          end
          s_left = int'(m_arlen) + 1;
          job_ars++;
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input int len, input bit bp, input int spur);
    int  nbeats, bp_phase, bp_cnt;
    bit  exp_err, spur_done, got_done;
    nbeats    = len / 16;
    exp_err   = (err_beat >= 0) && (err_beat < nbeats);
    bp_phase  = 0; bp_cnt = 0; spur_done = 0; got_done = 0;
    job_beats = 0; job_ars = 0; job_beat_sent = 0;
    build_model(base, len);
    @(negedge clk);
    start = 1; base_addr = base; length_bytes = 20'(len);
    @(negedge clk);
    start = 0;
    chk("start_clears_err", err, 0);
    if (len == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      repeat (5) @(negedge clk);
      chk("zero_no_ar", job_ars, 0);
      chk("zero_done_once", done, 0);
      return;
    end
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      @(negedge clk);
      start = 0;
      if (spur >= 0 && !spur_done && job_beats >= spur) begin
        start = 1; base_addr = 32'h5000; length_bytes = 20'd32; spur_done = 1;
      end
      if (bp && bp_phase == 0 && job_ars >= 1) begin
        dfsm_read_ready = 0; bp_phase = 1; bp_cnt = 0;
      end else if (bp_phase == 1) begin
        chk("bp_no_arvalid", m_arvalid, 0);
        bp_cnt++;
        if (bp_cnt == 20) begin dfsm_read_ready = 1; bp_phase = 2; end
      end else if (bp_phase == 2) begin
        chk("bp_ar_resume", m_arvalid, 1);
        bp_phase = 3;
      end
    end
    chk("done_seen", got_done, 1);
    chk("done_timing", cyc - last_pulse_cyc, 1);
    chk("beats_total", job_beats, nbeats);
    chk("bursts_left", exp_ar_addr.size(), 0);
    chk("busy_at_done", busy, 0);
    chk("err_at_done", err, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("err_sticky", err, exp_err);
    dfsm_read_ready = 1;
  endtask

  initial begin
    reset = 0; start = 0; base_addr = '0; length_bytes = '0; dfsm_read_ready = 1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1;
    @(negedge clk);

    run_job(32'h0000_0000, 512, 0, -1);          // two full bursts
    run_job(32'h0000_0FC0, 256, 0, -1);          // 4 KB split 4 + 12
    run_job(32'h0000_0000, 512, 1, -1);          // dfsm_read_ready low window
    gaps = 1; ar_rand = 1; err_beat = 5;
    run_job(32'h0000_0300, 256, 0, -1);          // SLVERR on beat 5
    err_beat = -1;
    run_job(32'h0000_0400, 64, 0, -1);           // err cleared by start
    run_job(32'h0000_0000, 0, 0, -1);            // zero length
    run_job(32'h0000_0800, 256, 0, 4);           // start while busy ignored

    // Reset during beat 7 of a job.
    job_beats = 0; job_ars = 0; job_beat_sent = 0;
    build_model(32'h0000_1000, 512);
    @(negedge clk);
    start = 1; base_addr = 32'h1000; length_bytes = 20'd512;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 2000 && job_beats < 7; c++) @(negedge clk);
    chk("rst_reached_beat7", (job_beats >= 7), 1);
    abort = 1; reset = 0;
    @(negedge clk);
    reset = 1;
    chk_reset_vals();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {bus_data_valid, m_arvalid, busy}, 3'b000);
    end
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    abort = 0;
    run_job(32'h0000_2000, 256, 0, -1);

    // Random jobs, some placed near a page edge.
    for (int j = 0; j < 6; j++) begin
      logic [31:0] b;
      gaps    = 1'($urandom_range(0, 1));
      ar_rand = 1'($urandom_range(0, 1));
      b = {$urandom_range(0, 3), 8'hFF, 4'h0} - 32'({$urandom_range(0, 20), 4'h0});
      run_job(b, 16 * $urandom_range(1, 64), 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
